// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer placed after uart_rx.
// Captures each rx_ready strobe and throttles uart_rx through rx_can_receive
// so that a frame already in flight always finds a free slot. Words that
// still arrive into a full buffer are dropped and flagged on a sticky
// overflow bit.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int SKID  = 1
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic [WIDTH-1:0]           rx_data,
   input  logic                       rx_ready,
   output logic                       rx_can_receive,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   input  logic                       flush,
   input  logic                       clear_overflow,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] SKID_L  = LW'(SKID);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);

   // Storage slots. The array is not reset: the pointers and the level
   // decide which slots hold valid words.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0] level_reg, level_next;
   logic          overflow_reg, overflow_next;

   logic push;
   logic pop;
   logic full;
   logic push_ok;
   logic drop;
   logic wr_en;

   // Handshake decode. A push into a full buffer still succeeds when a pop
   // frees a slot in the same cycle. Flush overrides both, so a word that
   // arrives during a flush is neither stored nor counted as a drop.
   always_comb begin
      push    = rx_ready;
      pop     = (level_reg != '0) && out_ready;
      full    = (level_reg == DEPTH_L);
      push_ok = push && (!full || pop);
      drop    = push && full && !pop && !flush;
      wr_en   = push_ok && !flush;
   end

   // Next-state computation for the pointers, the level and the sticky flag.
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      level_next    = level_reg;
      overflow_next = overflow_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         level_next  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   level_next = level_reg + LVL_ONE;
            2'b01:   level_next = level_reg - LVL_ONE;
            default: level_next = level_reg;
         endcase
      end
      // A drop wins over a coincident clear request.
      if (drop) begin
         overflow_next = 1'b1;
      end else if (clear_overflow) begin
         overflow_next = 1'b0;
      end
   end

   // State registers. Reset clears everything at once, without waiting for
   // a clock edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         level_reg    <= level_next;
         overflow_reg <= overflow_next;
      end
   end

   // Storage write port.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= rx_data;
      end
   end

   // Outputs come from registered state only. The head word is read
   // combinationally so that a word pushed into an empty buffer is visible
   // in the very next cycle.
   assign out_valid      = (level_reg != '0);
   assign out_data       = out_valid ? mem[rd_ptr_reg] : '0;
   assign rx_can_receive = (DEPTH_L - level_reg) > SKID_L;
   assign level          = level_reg;
   assign overflow       = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a table of vectors, directed corner-case
// sequences, and a randomized run, all checked against a queue-based
// reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int SKID  = 1;

   logic       clock;
   logic       resetn;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_can_receive;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       flush;
   logic       clear_overflow;
   logic       overflow;
   logic [4:0] level;

   int checks = 0;
   int errors = 0;

   // Reference model: the buffer contents as an ordered queue, plus the
   // sticky overflow flag.
   logic [7:0] q[$];
   logic       model_ov = 1'b0;

   uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH), .SKID(SKID)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .rx_can_receive (rx_can_receive),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .flush          (flush),
      .clear_overflow (clear_overflow),
      .overflow       (overflow),
      .level          (level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       rr;
      logic [7:0] rd;
      logic       orr;
      logic       fl;
      logic       clr;
      logic [4:0] lvl;
      logic       vld;
      logic [7:0] dat;
      logic       ovf;
      logic       can;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock edge as seen by the model.
   task automatic model_step(input logic rr, input logic [7:0] rd, input logic orr,
                             input logic fl, input logic clr);
      logic pop_m;
      logic drop_m;
      pop_m  = (q.size() != 0) && orr;
      drop_m = 1'b0;
      if (fl) begin
         q.delete();
      end else begin
         if (pop_m) void'(q.pop_front());
         if (rr) begin
            if (q.size() < DEPTH) q.push_back(rd);
            else drop_m = 1'b1;
         end
      end
      if (drop_m) model_ov = 1'b1;
      else if (clr) model_ov = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic [7:0] exp_data;
      exp_data = (q.size() != 0) ? q[0] : 8'h00;
      check({tag, ".level"}, 32'(level), 32'(q.size()));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
      check({tag, ".out_data"}, 32'(out_data), 32'(exp_data));
      check({tag, ".overflow"}, 32'(overflow), 32'(model_ov));
      check({tag, ".rx_can_receive"}, 32'(rx_can_receive), 32'((DEPTH - q.size()) > SKID));
   endtask

   // Called at a negedge: apply inputs for one posedge, then return to idle
   // at the next negedge and compare every output with the model.
   task automatic cycle(input logic rr, input logic [7:0] rd, input logic orr,
                        input logic fl, input logic clr, input string tag);
      rx_ready       = rr;
      rx_data        = rd;
      out_ready      = orr;
      flush          = fl;
      clear_overflow = clr;
      @(posedge clock);
      model_step(rr, rd, orr, fl, clr);
      @(negedge clock);
      rx_ready       = 1'b0;
      rx_data        = 8'h00;
      out_ready      = 1'b0;
      flush          = 1'b0;
      clear_overflow = 1'b0;
      check_model(tag);
   endtask

   // Stimulus and checking.
   initial begin
      logic [7:0] exp_seq[$];
      int pr;
      resetn         = 1'b0;
      rx_ready       = 1'b0;
      rx_data        = 8'h00;
      out_ready      = 1'b0;
      flush          = 1'b0;
      clear_overflow = 1'b0;

      vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 8'hA5, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 8'h3C, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 8'h5A, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1};

      // Reset state, observed while reset is still held.
      repeat (2) @(negedge clock);
      check_model("reset");
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check_model("post_reset");

      // Vector table: single push, hold stability, pop, push with pop.
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].rr, vecs[i].rd, vecs[i].orr, vecs[i].fl, vecs[i].clr, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.tbl_level", i), 32'(level), 32'(vecs[i].lvl));
         check($sformatf("vec%0d.tbl_valid", i), 32'(out_valid), 32'(vecs[i].vld));
         check($sformatf("vec%0d.tbl_data", i), 32'(out_data), 32'(vecs[i].dat));
         check($sformatf("vec%0d.tbl_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         check($sformatf("vec%0d.tbl_can", i), 32'(rx_can_receive), 32'(vecs[i].can));
      end

      // Fill 0x01..0x10; flow control drops once 15 words are stored.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, $sformatf("fill%0d", i));
         if (i == 14) check("fill14.can_high", 32'(rx_can_receive), 32'd1);
         if (i == 15) check("fill15.can_low", 32'(rx_can_receive), 32'd0);
      end
      check("full.level", 32'(level), 32'd16);

      // Push into full without a pop: dropped, overflow set, head unchanged.
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, "drop");
      check("drop.overflow", 32'(overflow), 32'd1);
      check("drop.head", 32'(out_data), 32'h01);
      check("drop.level", 32'(level), 32'd16);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ovf");
      check("clr_ovf.overflow", 32'(overflow), 32'd0);

      // A drop coinciding with clear_overflow leaves the flag set.
      cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, "drop_clr");
      check("drop_clr.overflow", 32'(overflow), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ovf2");

      // Full with push and pop together: both succeed.
      cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "full_pp");
      check("full_pp.level", 32'(level), 32'd16);
      check("full_pp.overflow", 32'(overflow), 32'd0);

      // Drain: 0x02..0x10 then 0x55.
      for (int i = 2; i <= 16; i++) exp_seq.push_back(8'(i));
      exp_seq.push_back(8'h55);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain%0d.data", i), 32'(out_data), 32'(exp_seq[i]));
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("drain%0d", i));
      end
      check("drained.valid", 32'(out_valid), 32'd0);

      // Twenty pushes with a pop every other cycle, then drain.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 8'(8'h20 + i), 1'(i % 2), 1'b0, 1'b0, $sformatf("wrap%0d", i));
      for (int i = 0; i < 12; i++)
         cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, $sformatf("wrapdrain%0d", i));
      check("wrapdrain.empty", 32'(level), 32'd0);

      // Level 5, then flush together with a push.
      for (int i = 0; i < 5; i++)
         cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0, $sformatf("pre_flush%0d", i));
      cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, "flush_push");
      check("flush_push.level", 32'(level), 32'd0);
      check("flush_push.valid", 32'(out_valid), 32'd0);

      // Fill past full so overflow is set, then pulse reset between edges.
      for (int i = 0; i < 17; i++)
         cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, $sformatf("pre_rst%0d", i));
      #2 resetn = 1'b0;
      #1;
      check("async_rst.level", 32'(level), 32'd0);
      check("async_rst.valid", 32'(out_valid), 32'd0);
      check("async_rst.data", 32'(out_data), 32'd0);
      check("async_rst.overflow", 32'(overflow), 32'd0);
      check("async_rst.can", 32'(rx_can_receive), 32'd1);
      q.delete();
      model_ov = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check_model("after_rst");

      // Randomized traffic with alternating fill-heavy and drain-heavy phases.
      for (int i = 0; i < 1600; i++) begin
         pr = ((i / 200) % 2 == 0) ? 25 : 80;
         cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < pr,
               $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
